pipeline_stall_ctrl: RTL and testbench

Pipeline control unit that consumes the data-hazard stall request, the PC-source selection and the memory-busy signal, and drives the write-enable and flush controls of PC, IF/ID, ID/EX and EX/MEM. It also keeps saturating statistics counters and a stall watchdog. It sits in the top-level CPU between the hazard detector, the ID-stage branch/jump logic, the data-memory/peripheral bus, and the pipeline registers.

---
 rtl/cpu_ctrl_pkg.sv | 21 ++
 rtl/sat_counter.sv | 33 +++
 rtl/pipeline_stall_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control definitions: next-PC select encodings and pipeline action states.
package cpu_ctrl_pkg;

  localparam logic [2:0] PCSRC_SEQ = 3'b000;
  localparam logic [2:0] PCSRC_JR  = 3'b001;
  localparam logic [2:0] PCSRC_J   = 3'b010;
  localparam logic [2:0] PCSRC_BR  = 3'b011;

  typedef enum logic [1:0] {
    ACT_RUN,
    ACT_HAZARD,
    ACT_FREEZE,
    ACT_REDIRECT
  } action_e;

  // Any PCSrc with the MSB set selects the exception vector.
  function automatic logic is_exception(input logic [2:0] pcsrc);
    return pcsrc[2];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline write-enable/flush control with FREEZE > HAZARD > REDIRECT > RUN priority,
// saturating statistics counters and a sticky consecutive-stall watchdog.
module pipeline_stall_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DataHazard,
  input  logic [2:0]       PCSrc,
  input  logic             MemBusy,
  input  logic             CntClear,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             StallTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic [CNT_W-1:0] FreezeCount
);

  localparam int unsigned RUN_W = $clog2(STALL_LIMIT + 1);
  localparam logic [RUN_W-1:0] LIMIT = RUN_W'(STALL_LIMIT);

  action_e prev_state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic timeout_q, timeout_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_state_q <= ACT_RUN;
      run_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      prev_state_q <= state_d;
      run_q        <= run_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d = ACT_RUN;
    if (MemBusy) begin
      state_d = ACT_FREEZE;
    end else if (DataHazard) begin
      state_d = ACT_HAZARD;
    end else if (PCSrc != PCSRC_SEQ) begin
      state_d = ACT_REDIRECT;
    end
  end

  always_comb begin
    PC_Write     = 1'b0;
    IF_ID_Write  = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Write  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Write = 1'b0;
    if (!reset) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else begin
      unique case (state_d)
        ACT_FREEZE: ;
        ACT_HAZARD: begin
          ID_EX_Write  = 1'b1;
          ID_EX_Flush  = 1'b1;
          EX_MEM_Write = 1'b1;
        end
        ACT_REDIRECT: begin
          PC_Write     = 1'b1;
          IF_ID_Write  = 1'b1;
          IF_ID_Flush  = 1'b1;
          ID_EX_Write  = 1'b1;
          ID_EX_Flush  = is_exception(PCSrc);
          EX_MEM_Write = 1'b1;
        end
        default: begin
          PC_Write     = 1'b1;
          IF_ID_Write  = 1'b1;
          ID_EX_Write  = 1'b1;
          EX_MEM_Write = 1'b1;
        end
      endcase
    end
  end

  // A hazard run continues only across HAZARD or FREEZE cycles; anything else restarts it.
  always_comb begin
    run_d     = run_q;
    timeout_d = timeout_q;
    if (CntClear) begin
      run_d     = '0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_d)
        ACT_HAZARD: begin
          if (prev_state_q != ACT_HAZARD && prev_state_q != ACT_FREEZE) begin
            run_d = RUN_W'(1);
          end else if (run_q < LIMIT) begin
            run_d = run_q + 1'b1;
          end
        end
        ACT_FREEZE: ;
        default: run_d = '0;
      endcase
      if (run_d >= LIMIT) begin
        timeout_d = 1'b1;
      end
    end
  end

  assign StallTimeout = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (state_d == ACT_HAZARD),
    .clr   (CntClear),
    .count (StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (state_d == ACT_REDIRECT),
    .clr   (CntClear),
    .count (FlushCount)
  );

  sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (state_d == ACT_FREEZE),
    .clr   (CntClear),
    .count (FreezeCount)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: table vectors plus hand-written multi-cycle sequences.
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic DataHazard, MemBusy, CntClear;
  logic [2:0] PCSrc;

  logic PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, StallTimeout;
  logic [15:0] StallCount, FlushCount, FreezeCount;

  logic b_pcw, b_ifw, b_iff, b_idw, b_idf, b_exw, b_to;
  logic [3:0] b_sc, b_fc, b_zc;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.STALL_LIMIT(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .DataHazard(DataHazard), .PCSrc(PCSrc), .MemBusy(MemBusy),
    .CntClear(CntClear), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush),
    .EX_MEM_Write(EX_MEM_Write), .StallTimeout(StallTimeout), .StallCount(StallCount),
    .FlushCount(FlushCount), .FreezeCount(FreezeCount)
  );

  // Narrow-counter instance sharing the stimulus, used for the saturation boundary.
  pipeline_stall_ctrl #(.STALL_LIMIT(3), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .DataHazard(DataHazard), .PCSrc(PCSrc), .MemBusy(MemBusy),
    .CntClear(CntClear), .PC_Write(b_pcw), .IF_ID_Write(b_ifw),
    .IF_ID_Flush(b_iff), .ID_EX_Write(b_idw), .ID_EX_Flush(b_idf),
    .EX_MEM_Write(b_exw), .StallTimeout(b_to), .StallCount(b_sc),
    .FlushCount(b_fc), .FreezeCount(b_zc)
  );

  // Control word order: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write}
  localparam logic [5:0] C_RUN = 6'b110101;
  localparam logic [5:0] C_HAZ = 6'b000111;
  localparam logic [5:0] C_RED = 6'b111101;
  localparam logic [5:0] C_EXC = 6'b111111;
  localparam logic [5:0] C_FRZ = 6'b000000;
  localparam logic [5:0] C_RST = 6'b001010;

  typedef struct {
    logic       mb;
    logic       dh;
    logic [2:0] pc;
    logic       clr;
    logic [5:0] exp;
  } vec_t;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [5:0] exp_q[$];

  int unsigned m_sc, m_fc, m_zc, m_sc4, m_run;
  logic m_to;

  task automatic check(input string name, input int unsigned got, input int unsigned want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_ctrl(input string name);
    logic [5:0] got, want;
    got = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write};
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty, got %b", name, got);
    end else begin
      want = exp_q.pop_front();
      check(name, 32'(got), 32'(want));
    end
  endtask

  task automatic model_reset();
    m_sc = 0; m_fc = 0; m_zc = 0; m_sc4 = 0; m_run = 0; m_to = 1'b0;
  endtask

  task automatic model_tick();
    logic hz, rd, fz;
    fz = MemBusy;
    hz = !MemBusy && DataHazard;
    rd = !MemBusy && !DataHazard && (PCSrc != 3'b000);
    if (CntClear) begin
      model_reset();
    end else begin
      if (hz && m_sc != 32'hFFFF) m_sc++;
      if (hz && m_sc4 != 15) m_sc4++;
      if (rd && m_fc != 32'hFFFF) m_fc++;
      if (fz && m_zc != 32'hFFFF) m_zc++;
      if (hz) m_run++;
      else if (!fz) m_run = 0;
      if (m_run >= 8) m_to = 1'b1;
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, ".StallCount"}, 32'(StallCount), m_sc);
    check({tag, ".FlushCount"}, 32'(FlushCount), m_fc);
    check({tag, ".FreezeCount"}, 32'(FreezeCount), m_zc);
    check({tag, ".StallTimeout"}, 32'(StallTimeout), 32'(m_to));
    check({tag, ".StallCount4"}, 32'(b_sc), m_sc4);
  endtask

  task automatic step(input string tag, input logic mb, input logic dh, input logic [2:0] pc,
                      input logic clr, input logic [5:0] exp);
    @(negedge clk);
    MemBusy = mb; DataHazard = dh; PCSrc = pc; CntClear = clr;
    exp_q.push_back(exp);
    #1;
    check_ctrl({tag, ".ctrl"});
    @(posedge clk);
    model_tick();
    #1;
    check_counters(tag);
  endtask

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 3'b000, 1'b0, C_RUN};
    vecs[1]  = '{1'b0, 1'b1, 3'b000, 1'b0, C_HAZ};
    vecs[2]  = '{1'b0, 1'b0, 3'b000, 1'b0, C_RUN};
    vecs[3]  = '{1'b0, 1'b1, 3'b011, 1'b0, C_HAZ};
    vecs[4]  = '{1'b0, 1'b1, 3'b011, 1'b0, C_HAZ};
    vecs[5]  = '{1'b0, 1'b0, 3'b011, 1'b0, C_RED};
    vecs[6]  = '{1'b0, 1'b0, 3'b001, 1'b0, C_RED};
    vecs[7]  = '{1'b0, 1'b0, 3'b010, 1'b0, C_RED};
    vecs[8]  = '{1'b0, 1'b0, 3'b100, 1'b0, C_EXC};
    vecs[9]  = '{1'b0, 1'b1, 3'b111, 1'b0, C_HAZ};
    vecs[10] = '{1'b1, 1'b1, 3'b011, 1'b0, C_FRZ};
    vecs[11] = '{1'b1, 1'b1, 3'b011, 1'b0, C_FRZ};
    vecs[12] = '{1'b1, 1'b1, 3'b011, 1'b0, C_FRZ};
    vecs[13] = '{1'b1, 1'b0, 3'b111, 1'b0, C_FRZ};
    vecs[14] = '{1'b0, 1'b0, 3'b111, 1'b0, C_EXC};
    vecs[15] = '{1'b0, 1'b1, 3'b000, 1'b1, C_HAZ};

    reset = 1'b0; MemBusy = 1'b0; DataHazard = 1'b1; PCSrc = 3'b011; CntClear = 1'b0;
    model_reset();
    #3;
    exp_q.push_back(C_RST);
    check_ctrl("reset.ctrl");
    check_counters("reset");
    @(negedge clk);
    reset = 1'b1; DataHazard = 1'b0; PCSrc = 3'b000;

    for (int i = 0; i < 16; i++) begin
      step($sformatf("vec%0d", i), vecs[i].mb, vecs[i].dh, vecs[i].pc, vecs[i].clr, vecs[i].exp);
    end

    // Watchdog: freeze cycles inside a stall run neither count nor break it.
    step("wd_clr", 1'b0, 1'b0, 3'b000, 1'b1, C_RUN);
    for (int i = 0; i < 4; i++) step("wd_haz_a", 1'b0, 1'b1, 3'b000, 1'b0, C_HAZ);
    for (int i = 0; i < 2; i++) step("wd_frz", 1'b1, 1'b1, 3'b000, 1'b0, C_FRZ);
    for (int i = 0; i < 3; i++) step("wd_haz_b", 1'b0, 1'b1, 3'b000, 1'b0, C_HAZ);
    check("wd_not_yet", 32'(StallTimeout), 0);
    step("wd_haz_8th", 1'b0, 1'b1, 3'b000, 1'b0, C_HAZ);
    check("wd_tripped", 32'(StallTimeout), 1);
    step("wd_sticky", 1'b0, 1'b0, 3'b000, 1'b0, C_RUN);
    check("wd_sticky_hold", 32'(StallTimeout), 1);
    step("wd_clear", 1'b0, 1'b0, 3'b000, 1'b1, C_RUN);
    check("wd_cleared", 32'(StallTimeout), 0);

    // Saturation of the 4-bit StallCount, then clear racing an increment.
    for (int i = 0; i < 18; i++) step("sat_haz", 1'b0, 1'b1, 3'b000, 1'b0, C_HAZ);
    check("sat_at_max", 32'(b_sc), 15);
    step("sat_clr_inc", 1'b0, 1'b1, 3'b000, 1'b1, C_HAZ);
    check("sat_clr_wins", 32'(StallCount), 0);

    // Reset between edges in the middle of a stall run.
    for (int i = 0; i < 5; i++) step("pre_rst_haz", 1'b0, 1'b1, 3'b000, 1'b0, C_HAZ);
    @(negedge clk);
    DataHazard = 1'b1; PCSrc = 3'b000; MemBusy = 1'b0; CntClear = 1'b0;
    exp_q.push_back(C_HAZ);
    #1;
    check_ctrl("mid_haz.ctrl");
    #1;
    reset = 1'b0;
    exp_q.push_back(C_RST);
    #1;
    check_ctrl("async_rst.ctrl");
    model_reset();
    check_counters("async_rst");
    @(posedge clk);
    #1;
    exp_q.push_back(C_RST);
    check_ctrl("rst_held.ctrl");
    check_counters("rst_held");
    @(negedge clk);
    reset = 1'b1; DataHazard = 1'b0;
    exp_q.push_back(C_RUN);
    #1;
    check_ctrl("rst_release.ctrl");
    check_counters("rst_release");
    @(posedge clk);
    model_tick();
    #1;
    check_counters("post_release");
    for (int i = 0; i < 7; i++) step("post_rst_haz", 1'b0, 1'b1, 3'b000, 1'b0, C_HAZ);
    check("post_rst_no_trip", 32'(StallTimeout), 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
